// File: rtl/dds_req_gen.sv
// Request sequencer for dds_ctrl: walks the DDS waveform RAM with a latched start
// address and increment, paces requests by a programmable gap and guards each ack.
module dds_req_gen #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 32,
  parameter int TMO    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_dds_en,
  input  logic [ADDR_W-1:0] reg_dds_start_addr,
  input  logic [ADDR_W-1:0] reg_dds_inc,
  input  logic [15:0]       reg_dds_period,
  input  logic [CNT_W-1:0]  reg_dds_len,
  input  logic              dds_ack,
  output logic              dds_req,
  output logic [ADDR_W-1:0] dds_addr,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam int TMO_W = (TMO > 2) ? $clog2(TMO) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_GAP,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_en_d;
  logic              r_req;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout_err;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_inc;
  logic [15:0]       r_period;
  logic [15:0]       r_gap_cnt;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_sample_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;

  logic              w_start;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic              w_last;
  logic              w_tmo_hit;

  assign w_start     = reg_dds_en & ~r_en_d;
  assign w_cnt_next  = r_sample_cnt + CNT_W'(1);
  // Carry out of the address add is dropped so the walk wraps modulo 2^ADDR_W.
  assign w_addr_next = r_addr + r_inc;
  assign w_last      = (r_len != '0) && (w_cnt_next == r_len);
  assign w_tmo_hit   = (r_tmo_cnt == TMO_W'(TMO - 1));

  // NOTE: all state is updated with non-blocking assignments so every register in
  // this block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_en_d        <= 1'b0;
      r_req         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_addr        <= '0;
      r_inc         <= '0;
      r_period      <= '0;
      r_gap_cnt     <= '0;
      r_len         <= '0;
      r_sample_cnt  <= '0;
      r_tmo_cnt     <= '0;
    end else begin
      r_en_d <= reg_dds_en;
      r_req  <= 1'b0;
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr        <= reg_dds_start_addr;
            r_inc         <= reg_dds_inc;
            r_period      <= reg_dds_period;
            r_len         <= reg_dds_len;
            r_sample_cnt  <= '0;
            r_timeout_err <= 1'b0;
            r_req         <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_tmo_cnt <= '0;
          r_state   <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (dds_ack) begin
            r_sample_cnt <= w_cnt_next;
            r_addr       <= w_addr_next;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (!reg_dds_en) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (r_period == 16'd0) begin
              r_req   <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_gap_cnt <= 16'd1;
              r_state   <= S_GAP;
            end
          end else if (w_tmo_hit) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (!reg_dds_en) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_gap_cnt == r_period) begin
            r_req   <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dds_req     = r_req;
  assign dds_addr    = r_addr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;
  assign sample_cnt  = r_sample_cnt;

endmodule
